contador_parte1: RTL and testbench
==================================

CONTADOR_PARTE1 -- requirements
Module: contador_parte1

Interface
REQ-001 Parameter WIDTH, default 8, counter width in bits.
REQ-002 Parameter RST_VAL, default 0, value loaded into the counter on reset.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (rst=0 resets; rst=1 runs).
REQ-005 up_down  input  1  direction select: 1 = count up, 0 = count down.
REQ-006 enable  input  1  count enable: 1 = step once per rising clk edge, 0 = hold.
REQ-007 conta  output  WIDTH  current count, driven directly from the count register.

Function
REQ-008 The block SHALL hold one WIDTH-bit count register; conta SHALL equal it at all times.
REQ-009 With rst=1, enable=1 and up_down=1, the count SHALL become count+1 modulo 2^WIDTH on each rising clk edge.
REQ-010 With rst=1, enable=1 and up_down=0, the count SHALL become count-1 modulo 2^WIDTH on each rising clk edge.
REQ-011 With rst=1 and enable=0, the count SHALL hold its value regardless of up_down.
REQ-012 Up wrap: 2^WIDTH-1 (8'hFF) SHALL step to 0 with no flag and no stall.
REQ-013 Down wrap: 0 SHALL step to 2^WIDTH-1 (8'hFF) with no flag and no stall.
REQ-014 Latency: a change in enable or up_down SHALL take effect at the first rising clk edge at which it is sampled; there is no pipelining.
REQ-015 up_down and enable SHALL be sampled only at rising clk edges; changes between edges SHALL have no effect.
REQ-016 Arithmetic SHALL be unsigned, modulo 2^WIDTH, with no saturation.
REQ-017 The block SHALL contain no combinational path from inputs to conta.

Reset
REQ-018 When rst=0, the count SHALL go to RST_VAL (8'h00) immediately, without waiting for clk.
REQ-019 While rst=0, conta SHALL stay at RST_VAL regardless of clk, enable and up_down.
REQ-020 When rst returns to 1 mid-operation, counting SHALL restart from RST_VAL at the first subsequent rising clk edge at which enable=1.
REQ-021 The block SHALL have no other state that requires initialisation.

Structure
REQ-022 WIDTH and RST_VAL defaults SHALL live in a shared counter package (e.g. contador_pkg), together with a count_t type of WIDTH bits.
REQ-023 A next-count sub-module, contador_next, is natural: combinational, inputs count, up_down and enable; output next count.
REQ-024 The top level SHALL hold only the asynchronous-reset register and instantiate contador_next.
REQ-025 The design SHALL contain no latches and no multicycle paths.
REQ-026 The design SHALL synthesise to WIDTH flip-flops plus an adder/subtractor.

Verification
REQ-027 Reset: rst=0 for 5 clocks with enable=1 -> conta=0 throughout; assert rst=0 between edges -> conta=0 immediately.
REQ-028 Down count: rst=1, enable=1, up_down=0 from conta=0 -> conta sequence 255, 254, 253, ... on successive edges.
REQ-029 Up count and wrap: enable=1, up_down=1 from conta=250 -> 251, ..., 255, 0, 1.
REQ-030 Hold: enable=0 for 10 clocks at conta=0x37, toggling up_down -> conta stays 0x37.
REQ-031 Direction switch mid-count: at conta=100 change up_down 0->1 -> next edge gives 101, not 99.
REQ-032 Reset mid-count: at conta=0x80, pulse rst=0 for 1 ns -> conta=0 at once; with enable=1 and up_down=1, conta=1 after the next edge.

Source files
------------

// File: rtl/contador_parte1_pkg.sv
// Shared counter defaults and the count type used by the counter block and its bench.
package contador_parte1_pkg;

    localparam int CNT_WIDTH   = 8;
    localparam int CNT_RST_VAL = 0;

    typedef logic [CNT_WIDTH-1:0] count_t;

endpackage : contador_parte1_pkg

// File: rtl/contador_parte1_if.sv
// Control/observation bundle of the up/down counter: the master drives direction
// and enable, the slave (the counter) drives the count.
interface contador_parte1_if
    import contador_parte1_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
) ();

    logic             up_down;
    logic             enable;
    logic [WIDTH-1:0] conta;

    modport master (
        output up_down,
        output enable,
        input  conta
    );

    modport slave (
        input  up_down,
        input  enable,
        output conta
    );

endinterface : contador_parte1_if

// File: rtl/contador_parte1_next.sv
// Combinational next-count logic: unsigned +1/-1 modulo 2^WIDTH, or hold.
module contador_next #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_count,
    input  logic             i_up_down,
    input  logic             i_enable,
    output logic [WIDTH-1:0] o_next
);

    // Wrap in both directions falls out of the truncating WIDTH-bit arithmetic.
    always_comb begin
        o_next = i_count;
        if (i_enable) begin
            if (i_up_down) begin
                o_next = i_count + WIDTH'(1);
            end else begin
                o_next = i_count - WIDTH'(1);
            end
        end
    end

endmodule : contador_next

// File: rtl/contador_parte1.sv
// Up/down counter: a single asynchronously reset count register fed by contador_next.
module contador_parte1
    import contador_parte1_pkg::*;
#(
    parameter int               WIDTH   = CNT_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(CNT_RST_VAL)
) (
    input  logic              clk,
    input  logic              rst,
    contador_parte1_if.slave  bus
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_next;

    contador_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .i_count   (r_count),
        .i_up_down (bus.up_down),
        .i_enable  (bus.enable),
        .o_next    (w_next)
    );

    // rst is active-low and asynchronous: the count clears without waiting for clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= RST_VAL;
        end else begin
            r_count <= w_next;
        end
    end

    assign bus.conta = r_count;

endmodule : contador_parte1

// File: tb/tb_contador_parte1.sv
// Directed bench for contador_parte1: stimulus queues expected counts, a monitor
// process pops and compares them against the live count.
module tb_contador_parte1;
    import contador_parte1_pkg::*;

    logic clk;
    logic rst;
    logic sample_tgl;

    contador_parte1_if #(.WIDTH(CNT_WIDTH)) bus ();

    contador_parte1 #(
        .WIDTH   (CNT_WIDTH),
        .RST_VAL (count_t'(CNT_RST_VAL))
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    string  exp_name_q[$];
    count_t exp_val_q[$];
    int     checks   = 0;
    int     failures = 0;
    string  mon_name;
    count_t mon_val;

    // Monitor: every sample request drains the expectation queue against the DUT.
    always @(sample_tgl) begin
        while (exp_val_q.size() > 0) begin
            mon_name = exp_name_q.pop_front();
            mon_val  = exp_val_q.pop_front();
            checks++;
            if (bus.conta !== mon_val) begin
                failures++;
                $display("FAIL %s: conta=%0d expected=%0d at t=%0t",
                         mon_name, bus.conta, mon_val, $time);
            end
        end
    end

    task automatic expect_cnt(input string name, input count_t val);
        exp_name_q.push_back(name);
        exp_val_q.push_back(val);
        sample_tgl = ~sample_tgl;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        sample_tgl      = 1'b0;
        rst             = 1'b0;
        bus.enable      = 1'b1;
        bus.up_down     = 1'b1;
        #2;
        expect_cnt("reset_async_initial", 8'h00);
        for (int i = 0; i < 5; i++) begin
            step();
            expect_cnt("reset_held_with_enable", 8'h00);
        end

        // Release and count down through the 0 -> 255 wrap.
        rst         = 1'b1;
        bus.up_down = 1'b0;
        step(); expect_cnt("down_wrap_255", 8'd255);
        step(); expect_cnt("down_254", 8'd254);
        step(); expect_cnt("down_253", 8'd253);
        step(); expect_cnt("down_252", 8'd252);
        step(); expect_cnt("down_251", 8'd251);
        step(); expect_cnt("down_250", 8'd250);

        // Count up through the 255 -> 0 wrap.
        bus.up_down = 1'b1;
        step(); expect_cnt("up_251", 8'd251);
        step(); expect_cnt("up_252", 8'd252);
        step(); expect_cnt("up_253", 8'd253);
        step(); expect_cnt("up_254", 8'd254);
        step(); expect_cnt("up_255", 8'd255);
        step(); expect_cnt("up_wrap_0", 8'd0);
        step(); expect_cnt("up_1", 8'd1);

        steps(54);
        expect_cnt("reach_0x37", 8'h37);

        bus.enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.up_down = ~bus.up_down;
            step();
            expect_cnt("hold_enable_low", 8'h37);
        end

        bus.enable  = 1'b1;
        bus.up_down = 1'b1;
        steps(46);
        expect_cnt("reach_101", 8'd101);
        bus.up_down = 1'b0;
        step(); expect_cnt("down_to_100", 8'd100);
        bus.up_down = 1'b1;
        step(); expect_cnt("switch_dir_101", 8'd101);

        // A direction glitch that settles before the edge must be ignored.
        bus.up_down = 1'b0;
        #2;
        bus.up_down = 1'b1;
        step(); expect_cnt("glitch_ignored_102", 8'd102);

        steps(26);
        expect_cnt("reach_0x80", 8'h80);
        rst = 1'b0;
        #1;
        expect_cnt("reset_pulse_immediate", 8'h00);
        rst = 1'b1;
        step(); expect_cnt("restart_after_reset", 8'd1);

        #2;
        if (exp_val_q.size() != 0) begin
            failures++;
            $display("FAIL monitor_drain: pending=%0d expected=0", exp_val_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule : tb_contador_parte1
